// File: rtl/sc_mat_addsub_mm.sv
// Avalon-MM complex matrix add/subtract engine: C = A +/- B, element by element.
// Define SC_MAT_ADDSUB_SAT_EN to saturate results; otherwise results wrap.
module sc_mat_addsub_mm #(
  parameter int unsigned MAT_NUM_ROW = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [63:0]       writedata,
  input  logic              write,
  input  logic              read,
  input  logic [7:0]        byteenable,
  output logic [63:0]       readdata,
  output logic              waitrequest,
  output logic              irq
);

  localparam int unsigned N     = MAT_NUM_ROW * MAT_NUM_ROW;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [ADDR_W-1:0] B_BASE    = ADDR_W'(N);
  localparam logic [ADDR_W-1:0] C_BASE    = ADDR_W'(2 * N);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(3 * N);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(3 * N + 1);

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_t;

`ifdef SC_MAT_ADDSUB_SAT_EN
  localparam elem_t ELEM_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam elem_t ELEM_MAX = {1'b0, {(DATA_W-1){1'b1}}};
`endif

  elem_t a_re [N];
  elem_t a_im [N];
  elem_t b_re [N];
  elem_t b_im [N];
  elem_t c_re [N];
  elem_t c_im [N];

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              mode_q, mode_d;
  logic              irq_en_q, irq_en_d;
  logic [IDX_W-1:0]  k_q, k_d;
  logic              rvalid_q, rvalid_d;
  logic [63:0]       readdata_q, readdata_d;

  logic              in_a, in_b, in_c, is_mem, is_ctrl, is_stat;
  logic [ADDR_W-1:0] base;
  logic [IDX_W-1:0]  idx;
  logic [63:0]       old_word, merged, rd_word;
  elem_t             new_re, new_im, res_re, res_im;
  logic [DATA_W:0]   sum_re, sum_im;
  logic              ovf_re, ovf_im;
  logic              mem_stall, wr_acc, rd_acc;
  logic              a_we, b_we, c_we;

  function automatic logic [63:0] pack(input elem_t re, input elem_t im);
    logic [63:0] w;
    w = '0;
    w[DATA_W-1:0]     = re;
    w[32+DATA_W-1:32] = im;
    return w;
  endfunction

  function automatic logic [DATA_W:0] addsub(input elem_t x, input elem_t y, input logic sub);
    logic [DATA_W:0] xe, ye;
    xe = {x[DATA_W-1], x};
    ye = {y[DATA_W-1], y};
    return sub ? (xe - ye) : (xe + ye);
  endfunction

  always_comb begin
    in_a    = (address < B_BASE);
    in_b    = (address >= B_BASE) && (address < C_BASE);
    in_c    = (address >= C_BASE) && (address < CTRL_ADDR);
    is_ctrl = (address == CTRL_ADDR);
    is_stat = (address == STAT_ADDR);
    is_mem  = in_a | in_b | in_c;
    base    = in_b ? B_BASE : (in_c ? C_BASE : '0);
    idx     = IDX_W'(address - base);
  end

  // Byte-enable merge against the stored word so unselected bytes keep their value.
  always_comb begin
    old_word = in_b ? pack(b_re[idx], b_im[idx]) : pack(a_re[idx], a_im[idx]);
    merged   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      merged[8*i +: 8] = byteenable[i] ? writedata[8*i +: 8] : old_word[8*i +: 8];
    end
    new_re = merged[DATA_W-1:0];
    new_im = merged[32+DATA_W-1:32];
  end

  always_comb begin
    rd_word = '0;
    if (in_a)         rd_word = pack(a_re[idx], a_im[idx]);
    else if (in_b)    rd_word = pack(b_re[idx], b_im[idx]);
    else if (in_c)    rd_word = pack(c_re[idx], c_im[idx]);
    else if (is_ctrl) rd_word[2:1] = {irq_en_q, mode_q};
    else if (is_stat) rd_word[2:0] = {ovf_q, done_q, busy_q};
  end

  always_comb begin
    sum_re = addsub(a_re[k_q], b_re[k_q], mode_q);
    sum_im = addsub(a_im[k_q], b_im[k_q], mode_q);
    ovf_re = sum_re[DATA_W] ^ sum_re[DATA_W-1];
    ovf_im = sum_im[DATA_W] ^ sum_im[DATA_W-1];
`ifdef SC_MAT_ADDSUB_SAT_EN
    res_re = ovf_re ? (sum_re[DATA_W] ? ELEM_MIN : ELEM_MAX) : elem_t'(sum_re[DATA_W-1:0]);
    res_im = ovf_im ? (sum_im[DATA_W] ? ELEM_MIN : ELEM_MAX) : elem_t'(sum_im[DATA_W-1:0]);
`else
    res_re = sum_re[DATA_W-1:0];
    res_im = sum_im[DATA_W-1:0];
`endif
  end

  // A simultaneous read+write is a write; matrix accesses stall while busy.
  always_comb begin
    mem_stall = is_mem & busy_q;
    wr_acc    = write & ~mem_stall;
    rd_acc    = read & ~write & ~rvalid_q & ~mem_stall;
    if (reset)      waitrequest = 1'b0;
    else if (write) waitrequest = mem_stall;
    else            waitrequest = read & ~rvalid_q;
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = done_q;
    ovf_d      = ovf_q;
    mode_d     = mode_q;
    irq_en_d   = irq_en_q;
    k_d        = k_q;
    rvalid_d   = 1'b0;
    readdata_d = '0;
    a_we       = wr_acc & in_a;
    b_we       = wr_acc & in_b;
    c_we       = 1'b0;

    if (rd_acc) begin
      rvalid_d   = 1'b1;
      readdata_d = rd_word;
    end

    case (state_q)
      IDLE: begin
        if (wr_acc && is_ctrl && byteenable[0]) begin
          mode_d   = writedata[1];
          irq_en_d = writedata[2];
          if (writedata[0]) begin
            state_d = RUN;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
            k_d     = '0;
          end
        end
      end
      RUN: begin
        c_we  = 1'b1;
        ovf_d = ovf_q | ovf_re | ovf_im;
        if (k_q == IDX_W'(N - 1)) state_d = DONE_ST;
        else                      k_d     = k_q + 1'b1;
      end
      DONE_ST: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      mode_q     <= 1'b0;
      irq_en_q   <= 1'b0;
      k_q        <= '0;
      rvalid_q   <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      mode_q     <= mode_d;
      irq_en_q   <= irq_en_d;
      k_q        <= k_d;
      rvalid_q   <= rvalid_d;
      readdata_q <= readdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (a_we) begin
      a_re[idx] <= new_re;
      a_im[idx] <= new_im;
    end
    if (b_we) begin
      b_re[idx] <= new_re;
      b_im[idx] <= new_im;
    end
    if (c_we) begin
      c_re[k_q] <= res_re;
      c_im[k_q] <= res_im;
    end
  end

  assign readdata = readdata_q;
  assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_sc_mat_addsub_mm.sv
// Directed bench for sc_mat_addsub_mm (MAT_NUM_ROW=2, DATA_W=32): vector table plus timing sequences.
module tb_sc_mat_addsub_mm;

  localparam logic [22:0] A_AD = 23'd0;
  localparam logic [22:0] B_AD = 23'd4;
  localparam logic [22:0] C_AD = 23'd8;
  localparam logic [22:0] CTRL = 23'd12;
  localparam logic [22:0] STAT = 23'd13;

  logic        clk = 1'b0;
  logic        reset;
  logic [22:0] address;
  logic [63:0] writedata;
  logic        write;
  logic        read;
  logic [7:0]  byteenable;
  logic [63:0] readdata;
  logic        waitrequest;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  sc_mat_addsub_mm #(.MAT_NUM_ROW(2), .DATA_W(32), .ADDR_W(23)) dut (
    .clk(clk), .reset(reset), .address(address), .writedata(writedata),
    .write(write), .read(read), .byteenable(byteenable), .readdata(readdata),
    .waitrequest(waitrequest), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit          wr;
    logic [22:0] addr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [63:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t vw(input logic [22:0] a, input logic [63:0] d, input logic [7:0] be);
    vec_t v;
    v.wr = 1'b1; v.addr = a; v.data = d; v.be = be; v.exp = '0;
    return v;
  endfunction

  function automatic vec_t vr(input logic [22:0] a, input logic [63:0] e);
    vec_t v;
    v.wr = 1'b0; v.addr = a; v.data = '0; v.be = '0; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%h expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic bus_wr(input logic [22:0] a, input logic [63:0] d, input logic [7:0] be, output int stalls);
    address = a; writedata = d; byteenable = be; write = 1'b1; stalls = 0;
    @(negedge clk);
    while (waitrequest && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    if (waitrequest) begin
      checks++; failures++;
      $display("FAIL wr_timeout@%0d: waitrequest stuck high", a);
    end
    tick();
    write = 1'b0;
  endtask

  task automatic bus_rd(input logic [22:0] a, output logic [63:0] d, output int stalls);
    address = a; read = 1'b1; stalls = 0; d = '0;
    @(negedge clk);
    while (waitrequest && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    if (waitrequest) begin
      checks++; failures++;
      $display("FAIL rd_timeout@%0d: waitrequest stuck high", a);
    end
    d = readdata;
    tick();
    read = 1'b0;
  endtask

  task automatic load_std();
    int s;
    for (int k = 0; k < 4; k++) begin
      bus_wr(A_AD + 23'(k), {32'(k), 32'(10 + k)}, 8'hFF, s);
      bus_wr(B_AD + 23'(k), {32'd100, 32'hFFFF_FFFB}, 8'hFF, s);
    end
  endtask

  logic [63:0] d;
  int          st;
  logic [63:0] exp_c0_add, exp_c1_sub;

  initial begin
    reset = 1'b1; address = '0; writedata = '0; write = 1'b0; read = 1'b0; byteenable = '0;
    idle(3);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_readdata", readdata, 64'd0);
    chk("rst_waitrequest", 64'(waitrequest), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    tick();
    bus_rd(STAT, d, st); chk("rst_status", d, 64'd0);
    bus_rd(CTRL, d, st); chk("rst_ctrl", d, 64'd0);

    for (int k = 0; k < 4; k++) begin
      tbl.push_back(vw(A_AD + 23'(k), {32'(k), 32'(10 + k)}, 8'hFF));
      tbl.push_back(vw(B_AD + 23'(k), {32'd100, 32'hFFFF_FFFB}, 8'hFF));
    end
    tbl.push_back(vw(CTRL, 64'h1, 8'hFF));
    tbl.push_back(vr(C_AD + 0, {32'd100, 32'd5}));
    tbl.push_back(vr(C_AD + 1, {32'd101, 32'd6}));
    tbl.push_back(vr(C_AD + 2, {32'd102, 32'd7}));
    tbl.push_back(vr(C_AD + 3, {32'd103, 32'd8}));
    tbl.push_back(vr(STAT, 64'h2));
    tbl.push_back(vr(CTRL, 64'h0));
    tbl.push_back(vw(CTRL, 64'h7, 8'hFF));
    tbl.push_back(vr(C_AD + 0, {32'hFFFF_FF9C, 32'd15}));
    tbl.push_back(vr(C_AD + 3, {32'hFFFF_FF9F, 32'd18}));
    tbl.push_back(vr(STAT, 64'h2));
    tbl.push_back(vr(CTRL, 64'h6));
    tbl.push_back(vr(A_AD + 1, {32'd1, 32'd11}));
    tbl.push_back(vr(B_AD + 2, {32'd100, 32'hFFFF_FFFB}));
    tbl.push_back(vw(A_AD + 3, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F));
    tbl.push_back(vw(A_AD + 3, 64'hCCCC_CCCC_DDDD_DDDD, 8'hF0));
    tbl.push_back(vr(A_AD + 3, 64'hCCCC_CCCC_BBBB_BBBB));
    tbl.push_back(vr(23'd20, 64'h0));
    tbl.push_back(vw(C_AD + 0, 64'h1234_5678_9ABC_DEF0, 8'hFF));
    tbl.push_back(vr(C_AD + 0, {32'hFFFF_FF9C, 32'd15}));
    tbl.push_back(vw(23'd20, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF));
    tbl.push_back(vr(23'd20, 64'h0));
    tbl.push_back(vw(STAT, 64'h0, 8'hFF));
    tbl.push_back(vr(STAT, 64'h2));
    tbl.push_back(vr(23'd14, 64'h0));
    tbl.push_back(vw(A_AD + 0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01));
    tbl.push_back(vr(A_AD + 0, 64'h0000_0000_0000_00FF));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) begin
        bus_wr(tbl[i].addr, tbl[i].data, tbl[i].be, st);
      end else begin
        bus_rd(tbl[i].addr, d, st);
        chk($sformatf("vec%0d_rd@%0d", i, tbl[i].addr), d, tbl[i].exp);
      end
    end

    // Simultaneous read and write: handled as a write, no read data.
    address = A_AD + 2; writedata = {32'h55, 32'h66}; byteenable = 8'hFF; write = 1'b1; read = 1'b1;
    @(negedge clk);
    chk("rdwr_waitrequest", 64'(waitrequest), 64'd0);
    tick();
    write = 1'b0; read = 1'b0;
    @(negedge clk);
    chk("rdwr_readdata_zero", readdata, 64'd0);
    tick();
    bus_rd(A_AD + 2, d, st); chk("rdwr_a2", d, {32'h55, 32'h66});

    // Add timing: status at t+6, read latency, readdata returns to 0.
    load_std();
    bus_wr(CTRL, 64'h1, 8'hFF, st); chk("start_no_stall", 64'(st), 64'd0);
    idle(5);
    bus_rd(STAT, d, st);
    chk("add_status_t6", d, 64'h2);
    chk("status_latency", 64'(st), 64'd1);
    @(negedge clk);
    chk("readdata_back_to_0", readdata, 64'd0);
    tick();
    bus_rd(C_AD + 2, d, st);
    chk("add_c2", d, {32'd102, 32'd7});
    chk("c_read_latency", 64'(st), 64'd1);

    // Subtract with irq: irq rises at t+6, cleared by next start.
    bus_wr(CTRL, 64'h7, 8'hFF, st);
    idle(4);
    @(negedge clk); chk("irq_t5", 64'(irq), 64'd0);
    tick();
    @(negedge clk); chk("irq_t6", 64'(irq), 64'd1);
    tick();
    bus_rd(C_AD + 0, d, st); chk("sub_c0", d, {32'hFFFF_FF9C, 32'd15});
    chk("irq_held", 64'(irq), 64'd1);
    bus_wr(CTRL, 64'h7, 8'hFF, st);
    @(negedge clk); chk("irq_clear_on_start", 64'(irq), 64'd0);
    tick();
    bus_rd(C_AD + 0, d, st); chk("sub_c0_again", d, {32'hFFFF_FF9C, 32'd15});

    // Stall: C[1] read at t+2 waits through t+6 and returns the new result.
    bus_wr(CTRL, 64'h1, 8'hFF, st);
    idle(1);
    bus_rd(C_AD + 1, d, st);
    chk("stall_cycles", 64'(st), 64'd5);
    chk("stall_c1", d, {32'd101, 32'd6});
    bus_wr(CTRL, 64'h1, 8'hFF, st);
    idle(1);
    bus_rd(STAT, d, st);
    chk("status_busy_t2", d, 64'h1);
    chk("status_no_stall", 64'(st), 64'd1);
    bus_wr(CTRL, 64'h7, 8'hFF, st);
    chk("ctrl_busy_no_stall", 64'(st), 64'd0);
    bus_rd(C_AD + 1, d, st); chk("busy_ctrl_ignored_c1", d, {32'd101, 32'd6});
    bus_rd(CTRL, d, st); chk("busy_ctrl_ignored_ctrl", d, 64'h0);

    // Overflow on add (C0) then subtract (C1).
`ifdef SC_MAT_ADDSUB_SAT_EN
    exp_c0_add = 64'h0000_0000_7FFF_FFFF;
    exp_c1_sub = 64'h0000_0000_8000_0000;
`else
    exp_c0_add = 64'h0000_0000_8000_0000;
    exp_c1_sub = 64'h0000_0000_7FFF_FFFF;
`endif
    load_std();
    bus_wr(A_AD + 0, 64'h0000_0000_7FFF_FFFF, 8'hFF, st);
    bus_wr(B_AD + 0, 64'h0000_0000_0000_0001, 8'hFF, st);
    bus_wr(A_AD + 1, 64'h0000_0000_8000_0000, 8'hFF, st);
    bus_wr(B_AD + 1, 64'h0000_0000_0000_0001, 8'hFF, st);
    bus_wr(CTRL, 64'h1, 8'hFF, st);
    bus_rd(C_AD + 0, d, st); chk("ovf_add_c0", d, exp_c0_add);
    bus_rd(STAT, d, st); chk("ovf_add_status", d, 64'h6);
    bus_wr(CTRL, 64'h3, 8'hFF, st);
    bus_rd(C_AD + 1, d, st); chk("ovf_sub_c1", d, exp_c1_sub);
    bus_rd(C_AD + 0, d, st); chk("sub_c0_no_ovf", d, 64'h0000_0000_7FFF_FFFE);
    bus_rd(STAT, d, st); chk("ovf_sub_status", d, 64'h6);
    load_std();
    bus_wr(CTRL, 64'h1, 8'hFF, st);
    bus_rd(STAT, d, st); bus_rd(C_AD + 3, d, st);
    bus_rd(STAT, d, st); chk("ovf_cleared_by_start", d, 64'h2);

    // Reset mid-run at t+3.
    bus_wr(CTRL, 64'h7, 8'hFF, st);
    idle(2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_waitrequest", 64'(waitrequest), 64'd0);
    chk("midrst_irq", 64'(irq), 64'd0);
    chk("midrst_readdata", readdata, 64'd0);
    tick();
    bus_rd(STAT, d, st); chk("midrst_status", d, 64'h0);
    bus_rd(CTRL, d, st); chk("midrst_ctrl", d, 64'h0);
    bus_wr(CTRL, 64'h1, 8'hFF, st);
    bus_rd(C_AD + 2, d, st); chk("after_rst_c2", d, {32'd102, 32'd7});
    bus_rd(STAT, d, st); chk("after_rst_status", d, 64'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sc_mat_addsub_mm.md
# sc_mat_addsub_mm

Avalon-MM slave that holds two complex matrices A and B, computes C = A + B or C = A − B element by element on command, and exposes C, control and status through the same 64-bit bus. It supersedes the fixed-function complex matrix-add wrapper in the SoC accelerator fabric. The additions are:
- a runtime add/subtract mode;
- a parametrised element width;
- sticky status and overflow flags;
- an interrupt;
- non-blocking start, with bus stalls only on conflicting accesses.

## Interface
- MAT_NUM_ROW, 2, matrix is MAT_NUM_ROW×MAT_NUM_ROW; N = MAT_NUM_ROW² complex elements per matrix
- DATA_W, 32, signed two's-complement width of each real/imag part; legal range 2..32
- ADDR_W, 23, word-address width
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- address  in  ADDR_W  64-bit word index
- writedata  in  64  element word: real part at bits [DATA_W-1:0], imag part at bits [32+DATA_W-1:32]
- write  in  1  write request
- read  in  1  read request
- byteenable  in  8  per-byte write enable
- readdata  out  64  registered read data; 0 when not valid
- waitrequest  out  1  stall; the request must be held until the cycle it is low
- irq  out  1  level interrupt = STATUS.done & CTRL.irq_en

## Operation
- Address map (word index):
  - A: 0..N-1
  - B: N..2N-1
  - C: 2N..3N-1 (read-only)
  - CTRL: 3N
  - STATUS: 3N+1 (read-only)
  - above 3N+1: unmapped
- Writes to A/B apply only the bytes enabled by byteenable. Bits of the element word outside the real/imag fields are stored as 0 and read back as 0.
- Writes to C, STATUS or unmapped addresses are accepted and discarded. Reads of unmapped addresses return 0.
- CTRL bits:
  - [0] start: write-1 pulse, not stored
  - [1] mode: 0 = add, 1 = subtract
  - [2] irq_en
  - CTRL reads back {start=0, mode, irq_en}
- STATUS bits:
  - [0] busy
  - [1] done (sticky)
  - [2] ovf (sticky)
- FSM states and transitions:
  - IDLE → RUN on a write to CTRL with writedata[0]=1 and byteenable[0]=1. That write latches mode and irq_en, clears done and ovf, and sets element index k=0.
  - RUN: each cycle computes C[k] = A[k] ± B[k] on real and imag parts independently, then k++. When k=N−1 completes, → DONE_ST.
  - DONE_ST (one cycle): busy←0, done←1, → IDLE.
- A CTRL write while busy is accepted and ignored entirely: mode and irq_en are unchanged and no restart occurs.
- Arithmetic: full-width DATA_W+1 signed result. ovf is set if any part of any element falls outside the DATA_W signed range.
- Simultaneous read and write in one cycle: treated as a write. The read is dropped and readdata stays 0.
- Reset mid-operation: the FSM returns to IDLE and busy, done, ovf, mode, irq_en, readdata, waitrequest and irq are all cleared. A/B/C contents are not reset and are undefined after power-up.

## Timing
- Reset values: readdata=0, waitrequest=0, irq=0, STATUS=0, CTRL=0.
- Write to A/B/CTRL/unmapped while not busy: completes in the request cycle with waitrequest=0.
- Read: waitrequest=1 in the first request cycle. In the next cycle waitrequest=0 and readdata is valid for exactly that cycle, then returns to 0. Latency is 1.
- Access to A/B/C (read or write) while busy: waitrequest is held at 1 until the cycle after busy falls, then the access proceeds with the normal timing above.
- STATUS and CTRL reads are never stalled by busy.
- Start write accepted in cycle t:
  - busy=1 from t+1
  - C[k] written at the end of cycle t+1+k
  - busy=0 and done=1 from t+N+2
  - irq rises in the same cycle as done when irq_en=1
- irq and done stay high until the next accepted start or reset.

## Configuration
- SC_MAT_ADDSUB_SAT_EN defined: each real/imag result saturates to the DATA_W signed limits, −2^(DATA_W−1) or 2^(DATA_W−1)−1. ovf is still set on any clip.
- Not defined: results wrap modulo 2^DATA_W and are sign-correct within DATA_W bits. ovf is set under the same condition.

## Test plan
Configuration for all scenarios: MAT_NUM_ROW=2, DATA_W=32, so N=4, A@0, B@4, C@8, CTRL@12, STATUS@13.
- Add:
  - Stimulus: A[k] = {imag=k, real=10+k}, B[k] = {imag=100, real=−5}; write CTRL=0x1.
  - Response: STATUS=0b010 at t+6. C[2] reads {imag=102, real=7} with readdata valid 1 cycle after the request.
- Subtract with irq:
  - Stimulus: same data; write CTRL=0x7.
  - Response: C[0] = {imag=−100, real=15}. irq=1 from t+6. A new CTRL start clears irq and done the next cycle.
- Overflow (see Configuration for the macro):
  - Stimulus: A[0].real = 0x7FFFFFFF, B[0].real = 1, add.
  - Response: ovf=1. C[0].real = 0x80000000 without the macro, 0x7FFFFFFF with SC_MAT_ADDSUB_SAT_EN.
- Stall:
  - Stimulus: read C[1] at t+2 during the run.
  - Response: waitrequest stays high through t+6 and falls at t+7 with the final C[1]. A STATUS read at t+2 returns busy=1 without stalling.
- Byte enables and unmapped addresses:
  - Stimulus: write A[3] = 0xAAAA_AAAA_BBBB_BBBB with byteenable 0x0F, then 0xCCCC_CCCC_DDDD_DDDD with 0xF0.
  - Response: A[3] = 0xCCCC_CCCC_BBBB_BBBB. A read of address 20 returns 0. A write to C[0] leaves C unchanged.
- Reset mid-run:
  - Stimulus: assert reset at t+3.
  - Response: next cycle STATUS=0, waitrequest=0, irq=0. A fresh start then completes normally.
